rob_flush: RTL
==============

ROB_FLUSH -- requirements
Module: rob_flush

Interface
REQ-001 SHALL have parameter SIZE, default 8: entry count; power of two, >= 2; PTR = $clog2(SIZE).
REQ-002 SHALL have parameter XLEN, default 32: value and destination width.
REQ-003 SHALL have parameters ITYPE_W, STORE_T and BRANCH_T, defaults 4, STORE and BRANCH from the shared types header: iType width and encodings.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_in  in  1  clock; all state updates on rising edge.
REQ-006 rst_in  in  1  synchronous active-high reset.
REQ-007 valid_in, iType_in, value_in, dest_in  in  1/ITYPE_W/XLEN/XLEN  issue request and entry payload.
REQ-008 ready_out  out  1  ROB can accept an issue this cycle.
REQ-009 inst_rob_ix_out  out  PTR  index assigned to the issuing instruction (tail).
REQ-010 cdb_valid_in, cdb_rob_ix_in, cdb_value_in, cdb_dest_in  in  1/PTR/XLEN/XLEN  CDB result broadcast.
REQ-011 cdb_mispredict_in  in  1  the CDB result is a mispredicted branch.
REQ-012 commit_ready_in  in  1  downstream (register file / store port) accepts the head entry.
REQ-013 commit_out  out  1  head entry is valid and ready to commit.
REQ-014 iType_out, value_out, dest_out  out  ITYPE_W/XLEN/XLEN  head entry payload.
REQ-015 flush_out  out  1  the committing head is a mispredicted branch, so all younger entries are discarded.
REQ-016 rd_ix_a_in, rd_ix_b_in  in  PTR  operand lookup indices.
REQ-017 rd_value_a_out, rd_value_b_out  out  XLEN  looked-up values.
REQ-018 rd_ready_a_out, rd_ready_b_out  out  1  looked-up value is valid.
REQ-019 count_out  out  PTR+1  number of occupied entries.

Function
REQ-020 head and tail SHALL be PTR+1-bit wrapping counters.
- count = tail - head (modulo 2^(PTR+1)).
- Entry i is occupied iff (i - head[PTR-1:0]) mod SIZE < count.
REQ-021 ready_out SHALL be count < SIZE && !flush_out, combinational.
- No same-cycle commit credit: a full ROB refuses issue even while committing.
REQ-022 On valid_in && ready_out, the ROB SHALL accept the issue:
- Write iType, value and dest to entry tail[PTR-1:0].
- Clear the entry's ready and mispredict bits.
- Increment tail.
- inst_rob_ix_out = tail[PTR-1:0] in the same cycle.
REQ-023 On cdb_valid_in to an occupied entry, the ROB SHALL:
- Write the value.
- Write dest only if the entry's iType == STORE_T.
- Set the entry's ready bit (stores included).
- Set the mispredict bit if iType == BRANCH_T and cdb_mispredict_in = 1.
REQ-024 A CDB write to an unoccupied entry SHALL be ignored entirely, including the case where that index issues in the same cycle; the issue data wins.
REQ-025 commit_out SHALL be count != 0 && ready[head]. Head outputs SHALL be combinational from entry head[PTR-1:0].
REQ-026 A commit SHALL occur when commit_out && commit_ready_in; head increments by 1 and one entry commits per cycle at most.
REQ-027 flush_out SHALL be commit_out && commit_ready_in && mispredict[head], combinational. On the next edge:
- tail <= head + 1.
- All ready and mispredict bits clear.
- That cycle's issue and CDB writes are discarded.
REQ-028 When issue and commit occur in the same cycle, count SHALL stay unchanged; the full-to-full and empty-to-empty transitions must be correct.
REQ-029 Lookup ports SHALL be combinational:
- rd_ready = occupied && ready[ix], rd_value = value[ix].
- CDB bypass: if cdb_valid_in, cdb_rob_ix_in == ix and the entry is occupied, then rd_ready = 1 and rd_value = cdb_value_in.
REQ-030 Index arithmetic SHALL wrap modulo SIZE with no bubbles at the wrap point.

Reset
REQ-031 When rst_in is sampled high, the ROB SHALL set head = tail = 0 and clear all SIZE ready and mispredict bits; payload arrays need not reset.
REQ-032 Outputs in the first cycle after reset SHALL be:
- ready_out = 1; commit_out = 0; flush_out = 0.
- count_out = 0; inst_rob_ix_out = 0.
REQ-033 Reset mid-operation SHALL discard all in-flight entries regardless of concurrent issue, CDB, or commit activity.

Verification (SIZE=8)
REQ-034 Issue 8 entries with no CDB activity -> count_out = 8, ready_out = 0; a 9th valid_in is not accepted and tail does not move.
REQ-035 Issue idx0-2, then CDB idx1 = 0x55, then idx0 = 0x11 -> commit_out stays 0 until idx0 is ready; then 0x11 commits, then 0x55, in order.
REQ-036 Issue STORE at idx0, then CDB value 0xAA and dest 0x100 -> commit shows value_out = 0xAA and dest_out = 0x100; a non-store entry keeps its issued dest.
REQ-037 Issue BRANCH idx0 plus 3 younger entries; CDB idx0 with mispredict -> on commit flush_out = 1 for one cycle, next cycle count_out = 0, ready_out = 1, and a new issue receives idx1.
REQ-038 Fill 8, commit 8, then issue again while committing with commit_ready_in toggling -> indices wrap 7 to 0, count_out stays correct, and commit holds while commit_ready_in = 0.
REQ-039 Lookup idx2 in the same cycle as CDB idx2 = 0x77 -> rd_ready = 1, rd_value = 0x77; the same lookup on an unoccupied index gives rd_ready = 0.

Source files
------------

// File: rtl/rob_flush.sv
// Reorder buffer with in-order commit, CDB writeback, operand lookup with CDB
// bypass, and a full flush of younger entries when a mispredicted branch commits.
module rob_flush #(
   parameter int unsigned          SIZE     = 8,
   parameter int unsigned          XLEN     = 32,
   parameter int unsigned          ITYPE_W  = 4,
   parameter logic [ITYPE_W-1:0]   STORE_T  = ITYPE_W'(3),
   parameter logic [ITYPE_W-1:0]   BRANCH_T = ITYPE_W'(5),
   localparam int unsigned         PTR      = $clog2(SIZE)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               valid_in,
   input  logic [ITYPE_W-1:0] iType_in,
   input  logic [XLEN-1:0]    value_in,
   input  logic [XLEN-1:0]    dest_in,
   output logic               ready_out,
   output logic [PTR-1:0]     inst_rob_ix_out,
   input  logic               cdb_valid_in,
   input  logic [PTR-1:0]     cdb_rob_ix_in,
   input  logic [XLEN-1:0]    cdb_value_in,
   input  logic [XLEN-1:0]    cdb_dest_in,
   input  logic               cdb_mispredict_in,
   input  logic               commit_ready_in,
   output logic               commit_out,
   output logic [ITYPE_W-1:0] iType_out,
   output logic [XLEN-1:0]    value_out,
   output logic [XLEN-1:0]    dest_out,
   output logic               flush_out,
   input  logic [PTR-1:0]     rd_ix_a_in,
   input  logic [PTR-1:0]     rd_ix_b_in,
   output logic [XLEN-1:0]    rd_value_a_out,
   output logic [XLEN-1:0]    rd_value_b_out,
   output logic               rd_ready_a_out,
   output logic               rd_ready_b_out,
   output logic [PTR:0]       count_out
);

   localparam logic [PTR:0] ONE  = (PTR+1)'(1);
   localparam logic [PTR:0] FULL = (PTR+1)'(SIZE);

   logic [PTR:0]         head;
   logic [PTR:0]         tail;
   logic [PTR:0]         count;
   logic [PTR-1:0]       head_ix;
   logic [PTR-1:0]       tail_ix;
   logic [SIZE-1:0]      rdy_q;
   logic [SIZE-1:0]      mis_q;
   logic [SIZE-1:0]      occ;
   logic [ITYPE_W-1:0]   itype_q [SIZE];
   logic [XLEN-1:0]      value_q [SIZE];
   logic [XLEN-1:0]      dest_q  [SIZE];
   logic                 issue;
   logic                 commit;
   logic                 cdb_hit;

   assign count   = tail - head;
   assign head_ix = head[PTR-1:0];
   assign tail_ix = tail[PTR-1:0];

   // Occupancy by distance from head; covers the full case where head_ix == tail_ix.
   always_comb begin
      occ = '0;
      for (int i = 0; i < int'(SIZE); i++) begin
         occ[i] = {1'b0, PTR'(i) - head_ix} < count;
      end
   end

   assign cdb_hit    = cdb_valid_in && occ[cdb_rob_ix_in];
   assign commit_out = (count != '0) && rdy_q[head_ix];
   assign commit     = commit_out && commit_ready_in;
   assign flush_out  = commit && mis_q[head_ix];
   assign ready_out  = (count < FULL) && !flush_out;
   assign issue      = valid_in && ready_out;

   assign inst_rob_ix_out = tail_ix;
   assign iType_out       = itype_q[head_ix];
   assign value_out       = value_q[head_ix];
   assign dest_out        = dest_q[head_ix];
   assign count_out       = count;

   // Pointers and status bits; a flush retires the head and empties everything younger.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         rdy_q <= '0;
         mis_q <= '0;
      end else if (flush_out) begin
         head  <= head + ONE;
         tail  <= head + ONE;
         rdy_q <= '0;
         mis_q <= '0;
      end else begin
         if (commit) begin
            head <= head + ONE;
         end
         if (issue) begin
            tail           <= tail + ONE;
            rdy_q[tail_ix] <= 1'b0;
            mis_q[tail_ix] <= 1'b0;
         end
         if (cdb_hit) begin
            rdy_q[cdb_rob_ix_in] <= 1'b1;
            if (itype_q[cdb_rob_ix_in] == BRANCH_T && cdb_mispredict_in) begin
               mis_q[cdb_rob_ix_in] <= 1'b1;
            end
         end
      end
   end

   // Payload storage; issue and CDB never target the same entry since issue slots are free.
   always_ff @(posedge clk_in) begin
      if (!rst_in && !flush_out) begin
         if (issue) begin
            itype_q[tail_ix] <= iType_in;
            value_q[tail_ix] <= value_in;
            dest_q[tail_ix]  <= dest_in;
         end
         if (cdb_hit) begin
            value_q[cdb_rob_ix_in] <= cdb_value_in;
            if (itype_q[cdb_rob_ix_in] == STORE_T) begin
               dest_q[cdb_rob_ix_in] <= cdb_dest_in;
            end
         end
      end
   end

   assign rd_ready_a_out = occ[rd_ix_a_in] &&
                           (rdy_q[rd_ix_a_in] || (cdb_valid_in && cdb_rob_ix_in == rd_ix_a_in));
   assign rd_value_a_out = (cdb_hit && cdb_rob_ix_in == rd_ix_a_in) ? cdb_value_in
                                                                     : value_q[rd_ix_a_in];
   assign rd_ready_b_out = occ[rd_ix_b_in] &&
                           (rdy_q[rd_ix_b_in] || (cdb_valid_in && cdb_rob_ix_in == rd_ix_b_in));
   assign rd_value_b_out = (cdb_hit && cdb_rob_ix_in == rd_ix_b_in) ? cdb_value_in
                                                                     : value_q[rd_ix_b_in];

endmodule
